// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a small byte FIFO.
// Bytes queue in the FIFO while a frame is on the line. The FSM pops the
// next byte on the edge it enters START, so frames run back to back.
module uart_tx #(
   parameter int CLKS_PER_BIT = 87,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          osc_clk,
   input  logic                          rst_n,
   input  logic                          i_Tx_DV,
   input  logic [7:0]                    i_Tx_Byte,
   output logic                          o_Tx_Ready,
   output logic                          o_Tx_Serial,
   output logic                          o_Tx_Active,
   output logic                          o_Tx_Done,
   output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baudCnt_q, baudCnt_d;
   logic [2:0]      bitIdx_q, bitIdx_d;
   logic [7:0]      shift_q, shift_d;
   logic            serial_q, serial_d;
   logic            active_q, active_d;
   logic            done_q, done_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wrPtr_q, wrPtr_d;
   logic [PW-1:0]   rdPtr_q, rdPtr_d;
   logic [7:0]      fifoMem [FIFO_DEPTH];
   logic            push;
   logic            pop;
   logic            fifoNotEmpty;

   assign o_Tx_Ready   = (count_q < DEPTH_C);
   assign o_Tx_Serial  = serial_q;
   assign o_Tx_Active  = active_q;
   assign o_Tx_Done    = done_q;
   assign o_Fifo_Count = count_q;

   // A write lands only when there is room. The FSM sees only the count
   // register, so a byte written this cycle cannot be popped this cycle.
   assign push         = i_Tx_DV && o_Tx_Ready;
   assign fifoNotEmpty = (count_q != '0);

   // Storage array: no reset needed, occupancy is tracked by the count.
   always_ff @(posedge osc_clk) begin
      if (push) begin
         fifoMem[wrPtr_q] <= i_Tx_Byte;
      end
   end

   // Pointers and count. A push and a pop on the same edge leave the count unchanged.
   always_comb begin
      count_d = count_q;
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (push) begin
         wrPtr_d = wrPtr_q + PW'(1);
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Frame sequencing. The stop-bit end goes straight to START when more bytes are waiting.
   always_comb begin
      state_d   = state_q;
      baudCnt_d = baudCnt_q;
      bitIdx_d  = bitIdx_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            if (fifoNotEmpty) begin
               state_d   = START;
               pop       = 1'b1;
               shift_d   = fifoMem[rdPtr_q];
               baudCnt_d = '0;
            end
         end
         START: begin
            if (baudCnt_q == BAUD_LAST) begin
               baudCnt_d = '0;
               bitIdx_d  = 3'd0;
               state_d   = DATA;
            end else begin
               baudCnt_d = baudCnt_q + BW'(1);
            end
         end
         DATA: begin
            if (baudCnt_q == BAUD_LAST) begin
               baudCnt_d = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               bitIdx_d  = bitIdx_q + 3'd1;
               if (bitIdx_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               baudCnt_d = baudCnt_q + BW'(1);
            end
         end
         STOP: begin
            if (baudCnt_q == BAUD_LAST) begin
               baudCnt_d = '0;
               if (fifoNotEmpty) begin
                  state_d = START;
                  pop     = 1'b1;
                  shift_d = fifoMem[rdPtr_q];
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baudCnt_d = baudCnt_q + BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered line outputs come from the next state, so they stay aligned with the FSM.
   always_comb begin
      serial_d = 1'b1;
      case (state_d)
         START:   serial_d = 1'b0;
         DATA:    serial_d = shift_d[0];
         default: serial_d = 1'b1;
      endcase
      active_d = (state_d != IDLE);
      done_d   = (state_d == STOP) && (baudCnt_d == BAUD_LAST);
   end

   // State register. Reset aborts any frame, flushes the queue and forces the line idle.
   always_ff @(posedge osc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         baudCnt_q <= '0;
         bitIdx_q  <= '0;
         shift_q   <= '0;
         serial_q  <= 1'b1;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
         count_q   <= '0;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
      end else begin
         state_q   <= state_d;
         baudCnt_q <= baudCnt_d;
         bitIdx_q  <= bitIdx_d;
         shift_q   <= shift_d;
         serial_q  <= serial_d;
         active_q  <= active_d;
         done_q    <= done_d;
         count_q   <= count_d;
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives uart_tx with table vectors, hand-written corner
// sequences and a random byte stream. A timeline model (a byte queue plus
// the edge at which the line next becomes free) predicts every cycle.
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       osc_clk;
   logic       rst_n;
   logic       i_Tx_DV;
   logic [7:0] i_Tx_Byte;
   logic       o_Tx_Ready;
   logic       o_Tx_Serial;
   logic       o_Tx_Active;
   logic       o_Tx_Done;
   logic [2:0] o_Fifo_Count;

   int         total      = 0;
   int         bad        = 0;
   int         cyc        = 0;
   int         nextFree   = 0;
   int         frameStart = 0;
   int         accepted   = 0;
   bit         frameOn    = 1'b0;
   logic [7:0] frameByte  = 8'h00;
   logic [7:0] modelQ[$];

   typedef struct {
      logic [7:0] data;
      logic [9:0] frameBits;
   } frameVec_t;

   typedef struct {
      logic [7:0] data;
      int         expCount;
      logic       expReady;
      logic       expSerial;
   } burstVec_t;

   uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .osc_clk(osc_clk),
      .rst_n(rst_n),
      .i_Tx_DV(i_Tx_DV),
      .i_Tx_Byte(i_Tx_Byte),
      .o_Tx_Ready(o_Tx_Ready),
      .o_Tx_Serial(o_Tx_Serial),
      .o_Tx_Active(o_Tx_Active),
      .o_Tx_Done(o_Tx_Done),
      .o_Fifo_Count(o_Fifo_Count)
   );

   // Free-running clock.
   initial osc_clk = 1'b0;
   always #5 osc_clk = ~osc_clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic resetModel();
      modelQ.delete();
      frameOn  = 1'b0;
      nextFree = 0;
   endtask

   // One clock edge: update the timeline model, apply inputs, compare every output.
   task automatic applyStimulus(input logic dv, input logic [7:0] data);
      int         sz;
      int         off;
      logic [9:0] bits;
      logic       inFrame;
      logic       expSer;
      i_Tx_DV   = dv;
      i_Tx_Byte = data;
      cyc++;
      sz = modelQ.size();
      if (sz > 0 && cyc >= nextFree) begin
         frameByte  = modelQ.pop_front();
         frameStart = cyc;
         frameOn    = 1'b1;
         nextFree   = cyc + FRAME;
      end
      if (dv && sz < DEPTH) begin
         modelQ.push_back(data);
         accepted++;
      end
      @(posedge osc_clk);
      #1;
      off     = cyc - frameStart;
      inFrame = frameOn && (off < FRAME);
      bits    = {1'b1, frameByte, 1'b0};
      expSer  = 1'b1;
      if (inFrame) begin
         expSer = bits[off / CPB];
      end
      checkOutput("model_serial", o_Tx_Serial, expSer);
      checkOutput("model_active", o_Tx_Active, inFrame);
      checkOutput("model_done", o_Tx_Done, inFrame && (off == FRAME - 1));
      checkOutput("model_count", o_Fifo_Count, modelQ.size());
      checkOutput("model_ready", o_Tx_Ready, modelQ.size() < DEPTH);
   endtask

   task automatic drainModel();
      for (int i = 0; i < 2000 && (modelQ.size() != 0 || cyc < nextFree); i++) begin
         applyStimulus(1'b0, 8'h00);
      end
   endtask

   // Test sequence.
   initial begin
      frameVec_t frameTbl[4];
      burstVec_t burstTbl[8];
      int        w;
      int        thresh;
      int        iter;

      frameTbl[0] = '{8'hA5, 10'b1101001010};
      frameTbl[1] = '{8'h01, 10'b1000000010};
      frameTbl[2] = '{8'h80, 10'b1100000000};
      frameTbl[3] = '{8'hFF, 10'b1111111110};

      burstTbl[0] = '{8'h10, 1, 1'b1, 1'b1};
      burstTbl[1] = '{8'h11, 1, 1'b1, 1'b0};
      burstTbl[2] = '{8'h12, 2, 1'b1, 1'b0};
      burstTbl[3] = '{8'h13, 3, 1'b1, 1'b0};
      burstTbl[4] = '{8'h14, 4, 1'b0, 1'b0};
      burstTbl[5] = '{8'h15, 4, 1'b0, 1'b0};
      burstTbl[6] = '{8'h16, 4, 1'b0, 1'b0};
      burstTbl[7] = '{8'h17, 4, 1'b0, 1'b0};

      rst_n     = 1'b1;
      i_Tx_DV   = 1'b0;
      i_Tx_Byte = 8'h00;
      #2 rst_n  = 1'b0;
      #1;
      checkOutput("reset_serial", o_Tx_Serial, 1'b1);
      checkOutput("reset_active", o_Tx_Active, 1'b0);
      checkOutput("reset_done", o_Tx_Done, 1'b0);
      checkOutput("reset_count", o_Fifo_Count, 3'd0);
      checkOutput("reset_ready", o_Tx_Ready, 1'b1);
      @(posedge osc_clk);
      @(posedge osc_clk);
      #1 rst_n = 1'b1;

      $display("[TB] single frames from idle");
      for (int v = 0; v < 4; v++) begin
         applyStimulus(1'b1, frameTbl[v].data);
         checkOutput("latency_still_high", o_Tx_Serial, 1'b1);
         for (int k = 0; k < FRAME; k++) begin
            applyStimulus(1'b0, 8'h00);
            checkOutput("frame_bit", o_Tx_Serial, frameTbl[v].frameBits[k / CPB]);
            checkOutput("frame_done", o_Tx_Done, k == FRAME - 1);
            checkOutput("frame_active", o_Tx_Active, 1'b1);
         end
         applyStimulus(1'b0, 8'h00);
         checkOutput("frame_end_serial", o_Tx_Serial, 1'b1);
         checkOutput("frame_end_active", o_Tx_Active, 1'b0);
      end

      $display("[TB] back-to-back frames");
      applyStimulus(1'b1, 8'h00);
      checkOutput("b2b_count1", o_Fifo_Count, 3'd1);
      w = cyc;
      applyStimulus(1'b1, 8'hFF);
      checkOutput("b2b_count2", o_Fifo_Count, 3'd1);
      applyStimulus(1'b1, 8'h55);
      checkOutput("b2b_count3", o_Fifo_Count, 3'd2);
      for (int i = 0; i < 200 && cyc < w + 2 * FRAME + 1; i++) begin
         applyStimulus(1'b0, 8'h00);
         if (cyc == w + FRAME + 1) begin
            checkOutput("b2b_start2_count", o_Fifo_Count, 3'd1);
            checkOutput("b2b_start2_serial", o_Tx_Serial, 1'b0);
         end
         if (cyc == w + 2 * FRAME + 1) begin
            checkOutput("b2b_start3_count", o_Fifo_Count, 3'd0);
            checkOutput("b2b_start3_serial", o_Tx_Serial, 1'b0);
         end
      end
      drainModel();

      $display("[TB] overflow burst");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, burstTbl[i].data);
         checkOutput("burst_count", o_Fifo_Count, burstTbl[i].expCount);
         checkOutput("burst_ready", o_Tx_Ready, burstTbl[i].expReady);
         checkOutput("burst_serial", o_Tx_Serial, burstTbl[i].expSerial);
      end
      drainModel();

      $display("[TB] write on the pop edge while full");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'h61 + 8'(i));
      end
      checkOutput("full_count", o_Fifo_Count, 3'd4);
      for (int i = 0; i < 200 && cyc + 1 < nextFree; i++) begin
         applyStimulus(1'b0, 8'h00);
      end
      checkOutput("full_ready", o_Tx_Ready, 1'b0);
      applyStimulus(1'b1, 8'hEE);
      checkOutput("full_drop_count", o_Fifo_Count, 3'd3);
      drainModel();

      $display("[TB] reset in the middle of a frame");
      applyStimulus(1'b1, 8'h81);
      w = cyc;
      applyStimulus(1'b1, 8'h42);
      applyStimulus(1'b1, 8'h24);
      for (int i = 0; i < 200 && cyc < w + FRAME + 1 + 16; i++) begin
         applyStimulus(1'b0, 8'h00);
      end
      checkOutput("pre_reset_serial", o_Tx_Serial, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_serial", o_Tx_Serial, 1'b1);
      checkOutput("midreset_active", o_Tx_Active, 1'b0);
      checkOutput("midreset_done", o_Tx_Done, 1'b0);
      checkOutput("midreset_count", o_Fifo_Count, 3'd0);
      checkOutput("midreset_ready", o_Tx_Ready, 1'b1);
      resetModel();
      for (int i = 0; i < 3; i++) begin
         @(posedge osc_clk);
         #1;
         checkOutput("reset_hold_serial", o_Tx_Serial, 1'b1);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'b0, 8'h00);
      end
      applyStimulus(1'b1, 8'h3C);
      checkOutput("post_reset_latency_high", o_Tx_Serial, 1'b1);
      applyStimulus(1'b0, 8'h00);
      checkOutput("post_reset_latency_low", o_Tx_Serial, 1'b0);
      drainModel();

      $display("[TB] random stream");
      accepted = 0;
      thresh   = 8;
      iter     = 0;
      while (accepted < 1000 && iter < 55000) begin
         if (iter % 256 == 0) begin
            thresh = $urandom_range(1, 15);
         end
         applyStimulus($urandom_range(0, 15) < thresh, 8'($urandom));
         iter++;
      end
      if (accepted < 1000) begin
         checkOutput("random_budget", accepted, 1000);
      end
      drainModel();
      checkOutput("final_idle_serial", o_Tx_Serial, 1'b1);
      checkOutput("final_idle_count", o_Fifo_Count, 3'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
